// File: rtl/mem_arbiter.sv
// Data memory array with a shared write port: the core store port (never stalled,
// buffered through an in-order FIFO) and an external valid/ready port with a starvation bound.
module mem_arbiter #(
    parameter int  NUM_MEM      = 16,
    parameter int  REG_WIDTH    = 32,
    parameter int  FIFO_DEPTH   = 4,
    parameter int  STARVE_LIMIT = 4,
    localparam int MEM_SELECT   = $clog2(NUM_MEM),
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_core_store_enable,
    input  logic [MEM_SELECT-1:0]          i_core_store_select,
    input  logic [REG_WIDTH-1:0]           i_core_store_word,
    input  logic                           i_ext_valid,
    output logic                           o_ext_ready,
    input  logic [MEM_SELECT-1:0]          i_ext_select,
    input  logic [REG_WIDTH-1:0]           i_ext_word,
    output logic [NUM_MEM*REG_WIDTH-1:0]   o_mem,
    output logic [CNT_W-1:0]               o_fifo_count,
    output logic                           o_busy,
    output logic                           o_overflow
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [REG_WIDTH-1:0]  mem_q [NUM_MEM];
    logic [MEM_SELECT-1:0] fifo_sel  [FIFO_DEPTH];
    logic [REG_WIDTH-1:0]  fifo_word [FIFO_DEPTH];

    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]    count_q, count_next;
    logic [STARVE_W-1:0] starve_q, starve_next;
    logic                overflow_q;

    logic                  starve_grant, fifo_empty, fifo_full, ext_xfer;
    logic                  wr_en, push_req, push_ok, pop, drop;
    logic [MEM_SELECT-1:0] wr_sel;
    logic [REG_WIDTH-1:0]  wr_word;

    assign starve_grant = (starve_q == STARVE_W'(STARVE_LIMIT));
    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == CNT_W'(FIFO_DEPTH));
    // Ready never looks at i_ext_valid, so the requester may wait on it freely.
    assign o_ext_ready  = starve_grant || (fifo_empty && !i_core_store_enable);
    assign ext_xfer     = i_ext_valid && o_ext_ready;

    // Write-source selection; exactly one array write per cycle at most.
    always_comb begin
        wr_en    = 1'b0;
        wr_sel   = '0;
        wr_word  = '0;
        push_req = 1'b0;
        pop      = 1'b0;
        if (starve_grant && i_ext_valid) begin
            wr_en    = 1'b1;
            wr_sel   = i_ext_select;
            wr_word  = i_ext_word;
            push_req = i_core_store_enable;
        end else if (!fifo_empty) begin
            wr_en    = 1'b1;
            wr_sel   = fifo_sel[rd_ptr_q];
            wr_word  = fifo_word[rd_ptr_q];
            pop      = 1'b1;
            push_req = i_core_store_enable;
        end else if (i_core_store_enable) begin
            wr_en    = 1'b1;
            wr_sel   = i_core_store_select;
            wr_word  = i_core_store_word;
        end else if (i_ext_valid) begin
            wr_en    = 1'b1;
            wr_sel   = i_ext_select;
            wr_word  = i_ext_word;
        end
    end

    // A full FIFO still accepts a push in a cycle that also pops.
    assign push_ok = push_req && (!fifo_full || pop);
    assign drop    = push_req && !push_ok;

    always_comb begin
        count_next = count_q;
        case ({push_ok, pop})
            2'b10:   count_next = count_q + CNT_W'(1);
            2'b01:   count_next = count_q - CNT_W'(1);
            default: count_next = count_q;
        endcase
    end

    always_comb begin
        starve_next = starve_q;
        if (!i_ext_valid || ext_xfer) begin
            starve_next = '0;
        end else if (!starve_grant) begin
            starve_next = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_MEM; k++) begin
                mem_q[k] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_sel] <= wr_word;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q  <= count_next;
            starve_q <= starve_next;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            fifo_sel[wr_ptr_q]  <= i_core_store_select;
            fifo_word[wr_ptr_q] <= i_core_store_word;
        end
    end

    for (genvar g = 0; g < NUM_MEM; g++) begin : g_mem_out
        assign o_mem[g*REG_WIDTH +: REG_WIDTH] = mem_q[g];
    end

    assign o_fifo_count = count_q;
    assign o_busy       = !fifo_empty;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for the basic paths plus
// hand-written sequences for collision, overflow and mid-operation reset.
module tb_mem_arbiter;

    localparam int NM = 16;
    localparam int RW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            core_en;
    logic [3:0]      core_sel;
    logic [RW-1:0]   core_word;
    logic            ext_valid;
    logic            ext_ready;
    logic [3:0]      ext_sel;
    logic [RW-1:0]   ext_word;
    logic [NM*RW-1:0] mem;
    logic [2:0]      fifo_count;
    logic            busy;
    logic            overflow;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_core_store_enable (core_en),
        .i_core_store_select (core_sel),
        .i_core_store_word   (core_word),
        .i_ext_valid         (ext_valid),
        .o_ext_ready         (ext_ready),
        .i_ext_select        (ext_sel),
        .i_ext_word          (ext_word),
        .o_mem               (mem),
        .o_fifo_count        (fifo_count),
        .o_busy              (busy),
        .o_overflow          (overflow)
    );

    typedef struct {
        logic        ce;
        logic [3:0]  cs;
        logic [31:0] cw;
        logic        ev;
        logic [3:0]  es;
        logic [31:0] ew;
        logic        exp_ready;
        int          exp_count;
        logic        exp_ovf;
        int          chk_addr;
        logic [31:0] chk_word;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] word_at(input int a);
        return mem[a*RW +: RW];
    endfunction

    function automatic void add(input logic ce, input logic [3:0] cs, input logic [31:0] cw,
                                input logic ev, input logic [3:0] es, input logic [31:0] ew,
                                input logic rdy, input int cnt, input logic ovf,
                                input int ca, input logic [31:0] cwd);
        vec_t v;
        v.ce = ce; v.cs = cs; v.cw = cw; v.ev = ev; v.es = es; v.ew = ew;
        v.exp_ready = rdy; v.exp_count = cnt; v.exp_ovf = ovf;
        v.chk_addr = ca; v.chk_word = cwd;
        vecs.push_back(v);
    endfunction

    // Drive at the falling edge, check ready before the rising edge, return just after it.
    task automatic cycle(input logic ce, input logic [3:0] cs, input logic [31:0] cw,
                         input logic ev, input logic [3:0] es, input logic [31:0] ew,
                         input logic exp_ready, input string tag);
        @(negedge clk);
        core_en = ce; core_sel = cs; core_word = cw;
        ext_valid = ev; ext_sel = es; ext_word = ew;
        #1;
        check({tag, " ready"}, 32'(ext_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; core_en = 1'b0; core_sel = '0; core_word = '0;
        ext_valid = 1'b0; ext_sel = '0; ext_word = '0;

        //   ce cs  cw            ev es  ew            rdy cnt ovf addr word
        add(1, 3, 32'hDEADBEEF, 0, 0,  32'h0,        0,  0,  0,  3,  32'hDEADBEEF);
        add(0, 0, 32'h0,        1, 5,  32'h12345678, 1,  0,  0,  5,  32'h12345678);
        add(1, 0, 32'd0,        1, 15, 32'hAA,       0,  0,  0,  0,  32'd0);
        add(1, 1, 32'd1,        1, 15, 32'hAA,       0,  0,  0,  1,  32'd1);
        add(1, 2, 32'd2,        1, 15, 32'hAA,       0,  0,  0,  2,  32'd2);
        add(1, 3, 32'd3,        1, 15, 32'hAA,       0,  0,  0,  3,  32'd3);
        add(1, 4, 32'd4,        1, 15, 32'hAA,       1,  1,  0,  4,  32'd0);
        add(1, 5, 32'd5,        0, 0,  32'h0,        0,  1,  0,  4,  32'd4);
        add(1, 6, 32'd6,        0, 0,  32'h0,        0,  1,  0,  5,  32'd5);
        add(1, 7, 32'd7,        0, 0,  32'h0,        0,  1,  0,  6,  32'd6);
        add(1, 8, 32'd8,        0, 0,  32'h0,        0,  1,  0,  7,  32'd7);
        add(1, 9, 32'd9,        0, 0,  32'h0,        0,  1,  0,  8,  32'd8);
        add(0, 0, 32'd0,        0, 0,  32'h0,        0,  0,  0,  9,  32'd9);
        add(0, 0, 32'd0,        0, 0,  32'h0,        1,  0,  0,  15, 32'hAA);

        repeat (2) @(posedge clk);
        #1;
        check("reset mem", 32'(mem === '0), 32'd1);
        check("reset count", 32'(fifo_count), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].ce, vecs[i].cs, vecs[i].cw, vecs[i].ev, vecs[i].es, vecs[i].ew,
                  vecs[i].exp_ready, $sformatf("v%0d", i));
            check($sformatf("v%0d count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].exp_count != 0));
            check($sformatf("v%0d ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            check($sformatf("v%0d word%0d", i, vecs[i].chk_addr),
                  word_at(vecs[i].chk_addr), vecs[i].chk_word);
        end

        // Same-address collision under a forced ext grant.
        for (int k = 0; k < 4; k++) begin
            cycle(1, 4'd7, 32'h70 + 32'(k), 1, 4'd2, 32'h1, 0, $sformatf("col%0d", k));
        end
        cycle(1, 4'd2, 32'h2, 1, 4'd2, 32'h1, 1, "col_grant");
        check("col word2 first", word_at(2), 32'h1);
        check("col count", 32'(fifo_count), 32'd1);
        cycle(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, "col_drain");
        check("col word2 final", word_at(2), 32'h2);
        check("col count drained", 32'(fifo_count), 32'd0);

        // Continuous core stores plus a blocked ext: each grant adds one FIFO entry.
        for (int k = 0; k < 25; k++) begin
            int exp_cnt;
            exp_cnt = (k + 1) / 5;
            if (exp_cnt > 4) exp_cnt = 4;
            cycle(1, 4'(k), 32'd100 + 32'(k), 1, 4'd14, 32'h55, (k % 5) == 4,
                  $sformatf("ovf%0d", k));
            check($sformatf("ovf%0d count", k), 32'(fifo_count), 32'(exp_cnt));
            check($sformatf("ovf%0d flag", k), 32'(overflow), 32'(k == 24));
        end
        check("ovf ext word", word_at(14), 32'h55);
        cycle(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, "drain1");
        check("drain1 count", 32'(fifo_count), 32'd3);
        check("ovf sticky", 32'(overflow), 32'd1);

        // Reset with three entries pending.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst2 count", 32'(fifo_count), 32'd0);
        check("rst2 busy", 32'(busy), 32'd0);
        check("rst2 ovf", 32'(overflow), 32'd0);
        check("rst2 mem", 32'(mem === '0), 32'd1);
        check("rst2 ready", 32'(ext_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post rst word14", word_at(14), 32'h0);
        check("post rst count", 32'(fifo_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the NUM_MEM x REG_WIDTH data memory array and shares its single write port between two requesters.
- Requester 1 is the core store port. It cannot stall, so it is never back-pressured.
- Requester 2 is an external loader/debug port with a valid/ready handshake.
- The core's stalls are absorbed by a small in-order store FIFO. A starvation counter bounds the wait on the external port. The full array is exported as the flattened read bus feeding the core's memory input.

Parameters:
- NUM_MEM, 16, number of memory words; MEM_SELECT = $clog2(NUM_MEM).
- REG_WIDTH, 32, word width.
- FIFO_DEPTH, 4, core store FIFO entries; power of two, >= 2.
- STARVE_LIMIT, 4, consecutive blocked cycles of ext before a forced grant; >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low (state reset when rst==0 at a rising edge of clk).
- i_core_store_enable  in  1  core store request this cycle.
- i_core_store_select  in  MEM_SELECT  core store address.
- i_core_store_word  in  REG_WIDTH  core store data.
- i_ext_valid  in  1  external write request.
- o_ext_ready  out  1  external write accepted this cycle (combinational).
- i_ext_select  in  MEM_SELECT  external write address.
- i_ext_word  in  REG_WIDTH  external write data.
- o_mem  out  NUM_MEM*REG_WIDTH  array contents; word k at bits [k*REG_WIDTH +: REG_WIDTH].
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- o_busy  out  1  FIFO non-empty.
- o_overflow  out  1  sticky: a core store was dropped.

Behaviour:
- Reset (rst==0 at edge): all array words 0, FIFO empty, starve counter 0, o_overflow 0. After reset, o_mem=0, o_fifo_count=0, o_busy=0.
- Exactly one array write per cycle, at most.
- starve_grant = (starve_cnt == STARVE_LIMIT).
- Write-source priority each cycle (first match wins):
  1. starve_grant && i_ext_valid: ext word commits; a concurrent core store is pushed to FIFO.
  2. FIFO non-empty: head commits and pops; a concurrent core store is pushed (order preserved).
  3. i_core_store_enable: direct commit of core store; no FIFO entry.
  4. i_ext_valid: ext word commits.
- o_ext_ready = starve_grant || (fifo_empty && !i_core_store_enable). It depends combinationally on i_core_store_enable, never on i_ext_valid.
- Ext transfer happens iff i_ext_valid && o_ext_ready. The requester must hold select/word stable until the transfer.
- starve_cnt update:
  - reset to 0 on an ext transfer or when i_ext_valid==0;
  - otherwise, if i_ext_valid && !o_ext_ready, increment, saturating at STARVE_LIMIT.
- Latency:
  - direct or ext commit is visible on o_mem the cycle after the edge;
  - a buffered core store commits in FIFO order, one per cycle, when not preempted by starve_grant.
- FIFO full with a core store needing a push:
  - if the same cycle pops (case 2), the push succeeds and the count is unchanged;
  - otherwise the store is dropped and o_overflow sets to 1. It clears only by reset.
- FIFO pointers wrap modulo FIFO_DEPTH. o_fifo_count ranges 0..FIFO_DEPTH.
- Same address written by ext and core in the same cycle: ext commits first, the buffered core word commits later, so the core value is the final value.
- Reads are not forwarded from the FIFO. o_mem reflects committed array state only. While o_busy==1, core loads may see stale data; the pipeline owner handles this using o_busy.
- Reset mid-operation: pending FIFO entries and starve state are discarded, and the array is cleared in the same edge.
- Out-of-range addresses are impossible by width. All address arithmetic is MEM_SELECT bits, unsigned.

Test Plan:
- Reset, then core store addr 3 = 0xDEADBEEF, ext idle -> after one edge, word 3 = 0xDEADBEEF, o_busy=0, o_fifo_count=0.
- Ext valid, addr 5 = 0x12345678, no core traffic -> o_ext_ready=1 same cycle; word 5 = 0x12345678 after edge; starve_cnt stays 0.
- Core stores every cycle for 10 cycles (addr i = i), ext valid addr 15 = 0xAA -> o_ext_ready low for 4 cycles, then high one cycle; ext commits; the core store pushed that cycle is buffered (count 1). Final words 0..9 = 0..9 and word 15 = 0xAA; FIFO drains to 0 after core traffic stops.
- Force FIFO full (FIFO_DEPTH=4) via repeated starve grants with continuous core stores, then a core store with no pop -> store dropped, o_overflow=1 and held until rst=0 applied.
- Same-address collision: forced ext grant writes addr 2 = 0x1 while core stores addr 2 = 0x2 -> word 2 = 0x1 after the first edge, 0x2 after the next.
- Assert rst=0 while o_fifo_count=3 -> after the edge, count 0, all words 0, o_overflow 0, o_ext_ready=1 with core idle.
